// File: rtl/cache_req_sched8.sv
// cache_req_sched8 -- 8-port round-robin request scheduler.
//
// Merges up to eight requesters onto one downstream request channel. Each
// port owns a 1-entry input buffer. A rotating-priority arbiter picks one
// buffered request per cycle into a registered output stage that is held
// under downstream backpressure.
//
// Optional feature macro: CACHE_SCHED_BURST_EN
//   defined   -> a port granted at the priority pointer may keep the pointer
//                for up to BURST_MAX consecutive grants
//   undefined -> pure round-robin, BURST_MAX only range-checked
//
// Parameters:
//   DATA_WIDTH  payload width per port
//   BURST_MAX   max consecutive grants to one port (1..15)
//
// Ports:
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset
//   i_valid  per-port request valid
//   i_data   port k payload at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_ready  per-port accept (combinational, depends on i_ready)
//   o_valid  output request valid (registered)
//   o_data   granted payload (registered)
//   o_src    index of the granted port (registered)
//   i_ready  downstream accept
//   o_busy   any buffer occupied or output valid
module cache_req_sched8 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              i_valid,
  input  logic [8*DATA_WIDTH-1:0] i_data,
  output logic [7:0]              o_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [2:0]              o_src,
  input  logic                    i_ready,
  output logic                    o_busy
);

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_burst_max_check
    $error("cache_req_sched8: BURST_MAX must be in 1..15");
  end

  logic [7:0]                 full;
  logic [7:0][DATA_WIDTH-1:0] data_buf;
  logic [2:0]                 ptr;
`ifdef CACHE_SCHED_BURST_EN
  logic [3:0]                 cnt;
`endif

  logic [2:0] grant;
  logic [2:0] cand;
  logic       any_full;
  logic       out_free;
  logic       load;
  logic [7:0] grant_oh;
  logic [7:0] accept;

  // Scan from the farthest offset down to ptr itself so the last hit,
  // i.e. the nearest full port at or after ptr, wins.
  always_comb begin
    grant = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr + 3'(7 - i);
      if (full[cand]) grant = cand;
    end
  end

  assign any_full = |full;
  assign out_free = ~o_valid | i_ready;
  assign load     = out_free & any_full;
  assign grant_oh = load ? (8'b1 << grant) : '0;

  // The port being drained this cycle can be refilled in the same cycle.
  assign o_ready  = ~full | grant_oh;
  assign accept   = i_valid & o_ready;
  assign o_busy   = any_full | o_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full     <= '0;
      data_buf <= '0;
      ptr      <= '0;
`ifdef CACHE_SCHED_BURST_EN
      cnt      <= '0;
`endif
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_src    <= '0;
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (accept[k]) data_buf[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end

      // Refill overrides the drain of the granted port.
      full <= (full & ~grant_oh) | accept;

      if (load) begin
        o_valid <= 1'b1;
        o_data  <= data_buf[grant];
        o_src   <= grant;
`ifdef CACHE_SCHED_BURST_EN
        if (grant == ptr && (32'(cnt) + 32'd1) < BURST_MAX) begin
          cnt <= cnt + 4'd1;
        end else begin
          ptr <= grant + 3'd1;
          cnt <= '0;
        end
`else
        ptr <= grant + 3'd1;
`endif
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_req_sched8.sv
// tb_cache_req_sched8 -- directed and random checks of cache_req_sched8
// against a behavioural model of the arbitration rules.
module tb_cache_req_sched8;

  localparam int unsigned DW = 8;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    i_valid;
  logic [8*DW-1:0] i_data;
  logic [7:0]    o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [2:0]    o_src;
  logic          i_ready;
  logic          o_busy;

  always #5 clk = ~clk;

  cache_req_sched8 #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_src(o_src),
    .i_ready(i_ready), .o_busy(o_busy)
  );

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  bit       m_full[8];
  bit [7:0] m_buf[8];
  int       m_ptr;
  int       m_cnt;
  bit       m_valid;
  bit [7:0] m_data;
  int       m_src;

  int       src_log[$];
  int       data_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 0;
      m_buf[k]  = 8'h00;
    end
    m_ptr = 0; m_cnt = 0; m_valid = 0; m_data = 8'h00; m_src = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".o_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".o_data"},  32'(o_data),  32'd0);
    chk({tag, ".o_src"},   32'(o_src),   32'd0);
    chk({tag, ".o_ready"}, 32'(o_ready), 32'hFF);
    chk({tag, ".o_busy"},  32'(o_busy),  32'd0);
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cycle(input logic [7:0] v, input logic [63:0] d, input logic r);
    int       g;
    bit       load;
    bit       any;
    bit [7:0] rdy;
    i_valid = v; i_data = d; i_ready = r;
    #1;
    g = -1;
    any = 0;
    for (int i = 0; i < 8; i++) begin
      int c;
      c = (m_ptr + i) % 8;
      if (g < 0 && m_full[c]) g = c;
      if (m_full[i]) any = 1;
    end
    load = (!m_valid || r) && (g >= 0);
    for (int k = 0; k < 8; k++) rdy[k] = !m_full[k] || (load && g == k);

    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_busy",  32'(o_busy),  32'(any || m_valid));
    chk("o_ready", 32'(o_ready), 32'(rdy));
    if (m_valid) begin
      chk("o_data", 32'(o_data), 32'(m_data));
      chk("o_src",  32'(o_src),  32'(m_src));
    end
    if (o_valid === 1'b1 && r) begin
      src_log.push_back(int'(o_src));
      data_log.push_back(int'(o_data));
    end

    if (load) begin
      m_data  = m_buf[g];
      m_src   = g;
      m_valid = 1;
      m_full[g] = 0;
`ifdef CACHE_SCHED_BURST_EN
      if (g == m_ptr && m_cnt + 1 < BM) m_cnt = m_cnt + 1;
      else begin
        m_ptr = (g + 1) % 8;
        m_cnt = 0;
      end
`else
      m_ptr = (g + 1) % 8;
`endif
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    for (int k = 0; k < 8; k++) begin
      if (v[k] && rdy[k]) begin
        m_buf[k]  = d[k*8 +: 8];
        m_full[k] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_valid = 8'($urandom);
    i_data  = {$urandom, $urandom};
    i_ready = 1'($urandom);
    #1;
    check_reset_vals("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    rstn = 1'b1;
  endtask

  initial begin
    logic [63:0] d;
    int exp_burst[8];

    // Reset with random inputs
    rstn = 1'b0;
    i_valid = 8'($urandom);
    i_data  = {$urandom, $urandom};
    i_ready = 1'($urandom);
    @(posedge clk);
    #1;
    do_reset();

    // Single request: port 3, 8'hA5
    d = '0;
    d[3*8 +: 8] = 8'hA5;
    cycle(8'h08, d, 1'b1);
    cycle(8'h00, '0, 1'b1);
    chk("single.o_valid", 32'(o_valid), 32'd1);
    chk("single.o_data",  32'(o_data),  32'hA5);
    chk("single.o_src",   32'(o_src),   32'd3);
    cycle(8'h00, '0, 1'b1);
    chk("single.o_valid_drop", 32'(o_valid), 32'd0);

    // Round-robin wrap from ptr=0
    do_reset();
    d = 64'h1716151413121110;
    cycle(8'hFF, d, 1'b1);
    src_log.delete();
    data_log.delete();
    for (int n = 0; n < 10; n++) cycle(8'h00, '0, 1'b1);
    chk("wrap.count", 32'(src_log.size()), 32'd8);
    for (int n = 0; n < 8 && n < src_log.size(); n++) begin
      chk("wrap.src",  32'(src_log[n]),  32'(n));
      chk("wrap.data", 32'(data_log[n]), 32'(8'h10 + n));
    end
    chk("wrap.idle", 32'(o_valid), 32'd0);

    // Ports 0 and 5 stream continuously; pointer left at 0 by the wrap
    src_log.delete();
    data_log.delete();
    for (int n = 0; n < 12; n++) begin
      d = '0;
      d[0 +: 8]  = 8'(8'h40 + n);
      d[40 +: 8] = 8'(8'h50 + n);
      cycle(8'h21, d, 1'b1);
    end
`ifdef CACHE_SCHED_BURST_EN
    exp_burst = '{0, 0, 0, 0, 5, 0, 0, 0};
    for (int n = 0; n < 5 && n < src_log.size(); n++)
      chk("burst.src", 32'(src_log[n]), 32'(exp_burst[n]));
`else
    exp_burst = '{0, 5, 0, 5, 0, 5, 0, 5};
    for (int n = 0; n < 8 && n < src_log.size(); n++)
      chk("rr.src", 32'(src_log[n]), 32'(exp_burst[n]));
`endif
    for (int n = 0; n < 4; n++) cycle(8'h00, '0, 1'b1);

    // Backpressure
    do_reset();
    d = '0;
    d[1*8 +: 8] = 8'h11;
    cycle(8'h02, d, 1'b0);
    d = '0;
    d[2*8 +: 8] = 8'h22;
    cycle(8'h04, d, 1'b0);
    for (int n = 0; n < 5; n++) begin
      cycle(8'h00, '0, 1'b0);
      chk("bp.hold_data", 32'(o_data), 32'h11);
      chk("bp.hold_src",  32'(o_src),  32'd1);
    end
    cycle(8'h00, '0, 1'b1);
    chk("bp.next_src",  32'(o_src),  32'd2);
    chk("bp.next_data", 32'(o_data), 32'h22);
    cycle(8'h00, '0, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      d = {$urandom, $urandom};
      cycle(8'($urandom), d, 1'($urandom_range(0, 3) != 0));
    end

    // Reset in the middle of traffic: 3 ports full plus a valid output
    do_reset();
    d = 64'h0000_0000_4433_2211;
    cycle(8'h0F, d, 1'b0);
    cycle(8'h00, '0, 1'b0);
    chk("midrst.pre_valid", 32'(o_valid), 32'd1);
    chk("midrst.pre_busy",  32'(o_busy),  32'd1);
    do_reset();
    src_log.delete();
    for (int n = 0; n < 4; n++) cycle(8'h00, '0, 1'b1);
    chk("midrst.no_stale", 32'(src_log.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
